// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_entry_t : one prefetch buffer entry, instruction word plus its pc
//   ifu_state_t   : fetch control states (FETCH issues requests, FLUSH waits
//                   for stale responses to drain after a redirect)
//   INST_BYTES    : pc step per fetched word
//   PC_ALIGN_MASK : clears the byte offset of a redirect target
// ---------------------------------------------------------------------------
package ifu_pkg;

  localparam int          INST_BYTES    = 4;
  localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } ifu_state_t;

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo
// Small synchronous FIFO with a registered head. Used both as the prefetch
// buffer and as the in-order tag queue that remembers the pc of each
// outstanding memory request.
// Ports:
//   CLK, Reset_L : clock, asynchronous active-low reset
//   push, din    : write din at the tail (ignored when full without a pop)
//   pop          : advance the head (ignored when empty)
//   clear        : drop every entry; takes priority over push and pop
//   count        : number of valid entries
//   head         : oldest entry; contents are stale when count is 0
// DEPTH does not have to be a power of two; pointers wrap explicitly.
// ---------------------------------------------------------------------------
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          Reset_L,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  T              din,
  output logic [CW-1:0] count,
  output T              head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // A full FIFO may still accept a push when the head leaves the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  assign head = mem[rd_ptr];

  // Storage and pointers. The array is reset so the head reads as zero
  // straight out of reset.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Requester side of the instruction memory read port. Issues word-aligned
// fetch addresses under a credit limit, buffers returned words in a prefetch
// FIFO and hands them to decode over a valid/ready handshake. A redirect
// flushes the buffer, reloads the fetch pc and drops the responses that are
// still in flight for the old path.
// Ports:
//   CLK, Reset_L              : clock, asynchronous active-low reset
//   mem_req, mem_addr         : one fetch request per cycle mem_req is high
//   mem_rdata, mem_rvalid     : in-order responses, variable latency
//   inst_valid, inst_ready    : decode handshake on the FIFO head
//   inst, inst_pc             : head instruction and its address
//   redirect_valid, redirect_pc : one-cycle branch/flush request
//   perf_fetched, perf_discarded : only with IFU_PERF_CNT_EN defined
// Build option: define IFU_PERF_CNT_EN to add the saturating counters.
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset_L,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  ifu_state_t   state;
  ifu_state_t   state_next;
  logic [63:0]  fetch_pc;
  logic [63:0]  fetch_pc_next;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_next;
  logic [OW-1:0] discard;
  logic [OW-1:0] discard_next;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] tag_count;
  logic [63:0]  tag_head;
  fetch_entry_t fifo_din;
  fetch_entry_t fifo_head;
  logic [5:0]   credit_used;
  logic         issue;
  logic         rsp_ok;
  logic         push;
  logic         pop;
  logic         head_valid;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok      = mem_rvalid && (outstanding != '0);
  assign credit_used = 6'(fifo_count) + 6'(outstanding);
  assign head_valid  = (fifo_count != '0);

  // Words land in the FIFO only when they belong to the current path; the
  // redirect cycle itself drops whatever response arrives with it.
  assign push = rsp_ok && (discard == '0) && !redirect_valid;
  assign pop  = head_valid && inst_ready && !redirect_valid;

  assign fifo_din = '{inst: mem_rdata, pc: tag_head};

  assign mem_req    = issue;
  assign mem_addr   = Reset_L ? fetch_pc : '0;
  assign inst_valid = Reset_L && head_valid && !redirect_valid;
  assign inst       = fifo_head.inst;
  assign inst_pc    = fifo_head.pc;

  assign outstanding_next = outstanding + OW'(issue) - OW'(rsp_ok);

  // Fetch control: decides whether to issue this cycle, where the next fetch
  // goes and how many stale responses are still to be dropped. A redirect
  // overrides everything. Any request still outstanding at that point is
  // stale, so the discard count is simply what remains outstanding after the
  // response landing in the same cycle.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    discard_next  = discard;
    issue         = 1'b0;

    if (rsp_ok && (discard != '0)) discard_next = discard - 1'b1;

    case (state)
      FETCH: begin
        issue = Reset_L && !redirect_valid &&
                (outstanding < OW'(MAX_OUT)) && (credit_used < 6'(DEPTH));
      end
      FLUSH: begin
        if (discard_next == '0) state_next = FETCH;
      end
    endcase

    if (issue) fetch_pc_next = fetch_pc + 64'(INST_BYTES);

    if (redirect_valid) begin
      fetch_pc_next = redirect_pc & PC_ALIGN_MASK;
      discard_next  = outstanding - OW'(rsp_ok);
      state_next    = (discard_next != '0) ? FLUSH : FETCH;
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
    end
  end

  // Prefetch buffer between memory and decode.
  ifu_fifo #(
    .DEPTH(DEPTH),
    .T    (fetch_entry_t)
  ) u_prefetch (
    .CLK    (CLK),
    .Reset_L(Reset_L),
    .push   (push),
    .pop    (pop),
    .clear  (redirect_valid),
    .din    (fifo_din),
    .count  (fifo_count),
    .head   (fifo_head)
  );

  // Tag queue: pc of every outstanding request, in issue order. It is never
  // flushed, because stale responses still arrive and must retire their tag.
  ifu_fifo #(
    .DEPTH(MAX_OUT),
    .T    (logic [63:0])
  ) u_tags (
    .CLK    (CLK),
    .Reset_L(Reset_L),
    .push   (issue),
    .pop    (rsp_ok),
    .clear  (1'b0),
    .din    (fetch_pc),
    .count  (tag_count),
    .head   (tag_head)
  );

  // Protocol and consistency checks, simulation only.
  a_rvalid_needs_request: assert property (@(posedge CLK) disable iff (!Reset_L)
    mem_rvalid |-> (outstanding != '0));
  a_tags_track_outstanding: assert property (@(posedge CLK) disable iff (!Reset_L)
    tag_count == outstanding);
  a_no_push_when_full: assert property (@(posedge CLK) disable iff (!Reset_L)
    push |-> ((fifo_count != CW'(DEPTH)) || pop));

`ifdef IFU_PERF_CNT_EN
  // Saturating event counters; a redirect does not clear them.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      if (push && (perf_fetched != '1)) perf_fetched <= perf_fetched + 1'b1;
      if (rsp_ok && !push && (perf_discarded != '1))
        perf_discarded <= perf_discarded + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit with default parameters
// (DEPTH 4, MAX_OUT 2, RESET_PC 0). A behavioural memory answers requests in
// order after a programmable latency. Inputs change 1 time unit after the
// rising edge and outputs are compared 1 unit later.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rvalid = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;
`endif

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int ncyc = 0;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  typedef struct {
    bit          rst;
    bit          ready;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [63:0] exp_pc;
  } vec_t;
  vec_t vecs[16];

  always #5 CLK = ~CLK;

  instruction_fetch_unit dut (
    .CLK           (CLK),
    .Reset_L       (Reset_L),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_discarded(perf_discarded)
`endif
  );

  // Memory image: a few fixed words, everything else derived from the address.
  function automatic logic [31:0] memword(input logic [63:0] a);
    case (a)
      64'h0:   return 32'hF84003E9;
      64'h4:   return 32'hF84083EA;
      64'h8:   return 32'hF84103EB;
      64'h2C:  return 32'hF80203ED;
      default: return a[31:0] ^ 32'h0000_0013;
    endcase
  endfunction

  // Memory model: works on the falling edge, where requests are stable.
  // A request seen here is accepted at the next rising edge; its response is
  // driven 'lat' falling edges later and held for one cycle.
  initial begin
    forever begin
      @(negedge CLK);
      ncyc++;
      if (!Reset_L) begin
        pend.delete();
        mem_rvalid = 1'b0;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEAD_BEEF;
        if (pend.size() > 0 && pend[0].due == ncyc) begin
          mem_rvalid = 1'b1;
          mem_rdata  = memword(pend[0].addr);
          pend.delete(0);
        end
        if (mem_req) pend.push_back('{addr: mem_addr, due: ncyc + lat});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rv,
                               input logic [63:0] rpc);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Hold reset over two edges, release 1 unit after a rising edge. The cycle
  // that follows the release is cycle 0.
  task automatic doReset();
    Reset_L = 1'b0;
    applyStimulus(1'b0, 1'b0, 64'h0);
    repeat (2) @(posedge CLK);
    #1;
    Reset_L = 1'b1;
  endtask

  function automatic vec_t mkv(input bit rst, input bit rdy, input logic req,
                               input logic [63:0] addr, input logic v,
                               input logic [31:0] i, input logic [63:0] pc);
    vec_t r;
    r.rst = rst; r.ready = rdy; r.exp_req = req; r.exp_addr = addr;
    r.exp_valid = v; r.exp_inst = i; r.exp_pc = pc;
    return r;
  endfunction

  initial begin
    bit found;

    // Reset stream, 1-cycle memory, decode always ready.
    vecs[0]  = mkv(1, 1, 1, 64'h00, 0, 32'h0, 64'h0);
    vecs[1]  = mkv(0, 1, 1, 64'h04, 0, 32'h0, 64'h0);
    vecs[2]  = mkv(0, 1, 1, 64'h08, 1, 32'hF84003E9, 64'h0);
    vecs[3]  = mkv(0, 1, 1, 64'h0C, 1, 32'hF84083EA, 64'h4);
    vecs[4]  = mkv(0, 1, 1, 64'h10, 1, 32'hF84103EB, 64'h8);
    vecs[5]  = mkv(0, 1, 1, 64'h14, 1, 32'h0000001F, 64'hC);
    // Backpressure: four requests fill the buffer, one pop frees one credit.
    vecs[6]  = mkv(1, 0, 1, 64'h00, 0, 32'h0, 64'h0);
    vecs[7]  = mkv(0, 0, 1, 64'h04, 0, 32'h0, 64'h0);
    vecs[8]  = mkv(0, 0, 1, 64'h08, 1, 32'hF84003E9, 64'h0);
    vecs[9]  = mkv(0, 0, 1, 64'h0C, 1, 32'hF84003E9, 64'h0);
    vecs[10] = mkv(0, 0, 0, 64'h00, 1, 32'hF84003E9, 64'h0);
    vecs[11] = mkv(0, 0, 0, 64'h00, 1, 32'hF84003E9, 64'h0);
    vecs[12] = mkv(0, 1, 0, 64'h00, 1, 32'hF84003E9, 64'h0);
    vecs[13] = mkv(0, 0, 1, 64'h10, 1, 32'hF84083EA, 64'h4);
    vecs[14] = mkv(0, 0, 0, 64'h00, 1, 32'hF84083EA, 64'h4);
    vecs[15] = mkv(0, 0, 0, 64'h00, 1, 32'hF84083EA, 64'h4);

    lat = 1;
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst) doReset();
      else step();
      applyStimulus(vecs[i].ready, 1'b0, 64'h0);
      #1;
      checkOutput($sformatf("row%0d_req", i), 64'(mem_req), 64'(vecs[i].exp_req));
      if (vecs[i].exp_req)
        checkOutput($sformatf("row%0d_addr", i), mem_addr, vecs[i].exp_addr);
      checkOutput($sformatf("row%0d_valid", i), 64'(inst_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("row%0d_inst", i), 64'(inst), 64'(vecs[i].exp_inst));
        checkOutput($sformatf("row%0d_pc", i), inst_pc, vecs[i].exp_pc);
      end
    end

    // Redirect with two requests in flight, 3-cycle memory.
    lat = 3;
    doReset();
    applyStimulus(1, 0, 64'h0); #1;
    checkOutput("redir_c0_addr", mem_addr, 64'h0);
    step(); #1;
    checkOutput("redir_c1_addr", mem_addr, 64'h4);
    step(); applyStimulus(1, 1, 64'h2F); #1;
    checkOutput("redir_c2_req", 64'(mem_req), 64'h0);
    step(); applyStimulus(1, 0, 64'h0); #1;
    checkOutput("flush_c3_req", 64'(mem_req), 64'h0);
    checkOutput("flush_c3_valid", 64'(inst_valid), 64'h0);
    step(); #1;
    checkOutput("flush_c4_req", 64'(mem_req), 64'h0);
    checkOutput("flush_c4_valid", 64'(inst_valid), 64'h0);
    step(); #1;
    checkOutput("refetch_req", 64'(mem_req), 64'h1);
    checkOutput("refetch_addr", mem_addr, 64'h2C);
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (inst_valid) found = 1;
      else begin step(); #1; end
    end
    checkOutput("refetch_found", 64'(found), 64'h1);
    checkOutput("refetch_pc", inst_pc, 64'h2C);
    checkOutput("refetch_inst", 64'(inst), 64'hF80203ED);

    // Redirect in the same cycle as a landing response and a ready head.
    lat = 1;
    doReset();
    applyStimulus(1, 0, 64'h0);
    step();
    step(); applyStimulus(1, 1, 64'h100); #1;
    checkOutput("coinc_valid", 64'(inst_valid), 64'h0);
    checkOutput("coinc_req", 64'(mem_req), 64'h0);
    step(); applyStimulus(1, 0, 64'h0); #1;
    checkOutput("coinc_next_req", 64'(mem_req), 64'h1);
    checkOutput("coinc_next_addr", mem_addr, 64'h100);
    checkOutput("coinc_next_valid", 64'(inst_valid), 64'h0);
    step(); #1;
    checkOutput("coinc_c4_valid", 64'(inst_valid), 64'h0);
    checkOutput("coinc_c4_addr", mem_addr, 64'h104);
    step(); #1;
    checkOutput("coinc_c5_valid", 64'(inst_valid), 64'h1);
    checkOutput("coinc_c5_pc", inst_pc, 64'h100);
    checkOutput("coinc_c5_inst", 64'(inst), 64'h113);

    // Wrap-around of the fetch pc.
    doReset();
    applyStimulus(1, 1, 64'hFFFF_FFFF_FFFF_FFFC); #1;
    checkOutput("wrap_c0_req", 64'(mem_req), 64'h0);
    step(); applyStimulus(1, 0, 64'h0); #1;
    checkOutput("wrap_c1_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(); #1;
    checkOutput("wrap_c2_req", 64'(mem_req), 64'h1);
    checkOutput("wrap_c2_addr", mem_addr, 64'h0);
    step(); #1;
    checkOutput("wrap_c3_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_c3_inst", 64'(inst), 64'hFFFF_FFEF);
    step(); #1;
    checkOutput("wrap_c4_pc", inst_pc, 64'h0);
    checkOutput("wrap_c4_inst", 64'(inst), 64'hF84003E9);

    // Reset asserted mid-cycle with a busy unit.
    doReset();
    applyStimulus(0, 0, 64'h0);
    repeat (6) step();
    applyStimulus(1, 0, 64'h0);
    step(); applyStimulus(0, 0, 64'h0); #1;
    checkOutput("pre_rst_addr", mem_addr, 64'h10);
    checkOutput("pre_rst_pc", inst_pc, 64'h4);
    #1;
    Reset_L = 1'b0;
    #1;
    checkOutput("rst_req", 64'(mem_req), 64'h0);
    checkOutput("rst_addr", mem_addr, 64'h0);
    checkOutput("rst_valid", 64'(inst_valid), 64'h0);
    checkOutput("rst_inst", 64'(inst), 64'h0);
    checkOutput("rst_pc", inst_pc, 64'h0);
    doReset();
    applyStimulus(1, 0, 64'h0); #1;
    checkOutput("post_rst_c0_req", 64'(mem_req), 64'h1);
    checkOutput("post_rst_c0_addr", mem_addr, 64'h0);
    checkOutput("post_rst_c0_valid", 64'(inst_valid), 64'h0);
    step(); #1;
    checkOutput("post_rst_c1_addr", mem_addr, 64'h4);
    step(); #1;
    checkOutput("post_rst_c2_valid", 64'(inst_valid), 64'h1);
    checkOutput("post_rst_c2_pc", inst_pc, 64'h0);
    checkOutput("post_rst_c2_inst", 64'(inst), 64'hF84003E9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
